// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single R/W memory port, fixed access latency.
// Optional round-robin on contention: define ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              m_en,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             pick1;

`ifdef ARB_ROUND_ROBIN_EN
  logic last;

  // last = 1 means r1 was served most recently, so r0 wins a tie
  always_comb begin
    pick1 = r1_req & (~r0_req | ~last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (state == IDLE && (r0_req | r1_req)) begin
      last <= pick1;
    end
  end
`else
  always_comb begin
    pick1 = r1_req & ~r0_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      grant    <= 1'b0;
      m_en     <= 1'b0;
      m_rw     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (r0_req | r1_req) begin
            grant   <= pick1;
            m_en    <= 1'b1;
            m_rw    <= pick1 ? r1_rw : r0_rw;
            m_addr  <= pick1 ? r1_addr : r0_addr;
            m_wdata <= pick1 ? r1_wdata : r0_wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= ACCESS;
          end else begin
            m_en <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!m_rw) begin
              if (grant) r1_rdata <= m_rdata;
              else       r0_rdata <= m_rdata;
            end
            m_en   <= 1'b0;
            m_rw   <= 1'b0;
            r0_ack <= ~grant;
            r1_ack <= grant;
            state  <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
